// File: rtl/ctrl_pkg.sv
// Shared definitions for the Mini SRC control sequencer.
// Contents: opcode values, FSM state encoding, instruction classes and the opcode classifier.
package ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_FWAIT, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7,
    S_LDWAIT, S_STWAIT, S_HALT, S_STEP_IDLE
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NONE, C_HALT
  } op_class_t;

  // Reserved opcodes 11100-11111 fall into C_NONE and behave like nop.
  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:   return C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:        return C_IMM;
      OP_LDI:                          return C_LDI;
      OP_LD:                           return C_LD;
      OP_ST:                           return C_ST;
      OP_MUL, OP_DIV:                  return C_MULDIV;
      OP_NEG, OP_NOT:                  return C_NEGNOT;
      OP_BR:                           return C_BR;
      OP_JR:                           return C_JR;
      OP_JAL:                          return C_JAL;
      OP_IN:                           return C_IN;
      OP_OUT:                          return C_OUT;
      OP_MFHI:                         return C_MFHI;
      OP_MFLO:                         return C_MFLO;
      OP_HALT:                         return C_HALT;
      default:                         return C_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state counter: cleared by load, advanced by count, saturates at 15.
// o_done flags the final wait cycle, after which the count has reached WAIT_CYCLES.
module ctrl_wait_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_cnt <= '0;
    else if (i_load)                   r_cnt <= '0;
    else if (i_count && r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
  end

  assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch, memory waits and T3..T7 execute sequencing.
// MEM_WAIT_CYCLES sets wait states per memory access; define CTRL_SINGLE_STEP_EN for step mode.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        run,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout_en,
  output logic        IncPC,
  output logic        PC_en,
  output logic        IRin,
  output logic        jal_R15,
  output logic        Yin,
  output logic        HIout,
  output logic        HIin,
  output logic        LOout,
  output logic        LOin,
  output logic        Cout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Zin,
  output logic        MDRout,
  output logic        MDRin,
  output logic        MARin,
  output logic        memRead,
  output logic        memWrite,
  output logic        CONin,
  output logic        inPortOut,
  output logic        outPort_en,
  output logic [4:0]  opcode
);

  state_t    r_state, w_next;
  op_class_t w_class;
  logic      w_load, w_count, w_done, w_step_rise;
  logic      w_unused_ir;

  assign w_class     = classify(ir[31:27]);
  assign w_unused_ir = ^ir[26:0];

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t DONE_STATE = S_STEP_IDLE;
  logic r_step_d;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_step_d <= 1'b0;
    else        r_step_d <= step;
  end
  assign w_step_rise = step & ~r_step_d;
`else
  localparam state_t DONE_STATE = S_F0;
  assign w_step_rise = 1'b0;
`endif

  ctrl_wait_timer #(.WAIT_CYCLES(MEM_WAIT_CYCLES)) u_wait (
    .i_clk   (clock),
    .i_rst_n (clear),
    .i_load  (w_load),
    .i_count (w_count),
    .o_done  (w_done)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_count = 1'b0;
    case (r_state)
      S_RST:   w_next = S_F0;
      S_F0:    w_next = S_F1;
      S_F1:    begin w_next = S_FWAIT; w_load = 1'b1; end
      S_FWAIT: begin w_count = 1'b1; if (w_done) w_next = S_F2; end
      S_F2:    case (w_class)
                 C_NONE:  w_next = DONE_STATE;
                 C_HALT:  w_next = S_HALT;
                 default: w_next = S_T3;
               endcase
      S_T3:    case (w_class)
                 C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: w_next = DONE_STATE;
                 default:                           w_next = S_T4;
               endcase
      S_T4:    case (w_class)
                 C_NEGNOT, C_JAL: w_next = DONE_STATE;
                 default:         w_next = S_T5;
               endcase
      S_T5:    case (w_class)
                 C_ALU, C_IMM, C_LDI: w_next = DONE_STATE;
                 default:             w_next = S_T6;
               endcase
      S_T6:    case (w_class)
                 C_LD:    begin w_next = S_LDWAIT; w_load = 1'b1; end
                 C_ST:    w_next = S_T7;
                 default: w_next = DONE_STATE;
               endcase
      S_T7:    if (w_class == C_ST) begin
                 w_next = S_STWAIT;
                 w_load = 1'b1;
               end else begin
                 w_next = DONE_STATE;
               end
      S_LDWAIT: begin w_count = 1'b1; if (w_done) w_next = S_T7; end
      S_STWAIT: begin w_count = 1'b1; if (w_done) w_next = DONE_STATE; end
      S_HALT:      w_next = S_HALT;
      S_STEP_IDLE: if (w_step_rise) w_next = S_F0;
      default:     w_next = S_RST;
    endcase
  end

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IRin, jal_R15} = '0;
    {Yin, HIout, HIin, LOout, LOin, Cout, Zhighout, Zlowout, Zin} = '0;
    {MDRout, MDRin, MARin, memRead, memWrite, CONin, inPortOut, outPort_en} = '0;
    opcode = OP_NOP;
    run    = 1'b1;
    case (r_state)
      S_F0:     begin PCout_en = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_F1:     begin Zlowout = 1'b1; PC_en = 1'b1; memRead = 1'b1; MDRin = 1'b1; end
      S_FWAIT,
      S_LDWAIT: begin memRead = 1'b1; MDRin = 1'b1; end
      S_F2:     begin MDRout = 1'b1; IRin = 1'b1; end
      S_STWAIT: memWrite = 1'b1;
      S_HALT:   run = 1'b0;
      S_T3: case (w_class)
        C_ALU, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        C_NEGNOT: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir[31:27]; end
        C_BR:     begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        C_JR:     begin Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; end
        C_JAL:    begin PCout_en = 1'b1; jal_R15 = 1'b1; Rin = 1'b1; end
        C_IN:     begin inPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_OUT:    begin Gra = 1'b1; Rout = 1'b1; outPort_en = 1'b1; end
        C_MFHI:   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_MFLO:   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        default:  ;
      endcase
      S_T4: case (w_class)
        C_ALU:    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir[31:27]; end
        C_IMM:    begin Cout = 1'b1; Zin = 1'b1; opcode = ir[31:27]; end
        C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
        C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir[31:27]; end
        C_NEGNOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_BR:     begin PCout_en = 1'b1; Yin = 1'b1; end
        C_JAL:    begin Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; end
        default:  ;
      endcase
      S_T5: case (w_class)
        C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
        C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
        C_BR:       begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
        default:    ;
      endcase
      // The only strobe allowed to follow con_ff: the conditional PC load of br.
      S_T6: case (w_class)
        C_LD:     begin memRead = 1'b1; MDRin = 1'b1; end
        C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
        C_BR:     begin Zlowout = 1'b1; PC_en = con_ff; end
        default:  ;
      endcase
      S_T7: case (w_class)
        C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_ST:    memWrite = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle strobe/opcode/run checks against
// a per-instruction expected-cycle list built from the Mini SRC instruction timing tables.
module tb_control_sequencer;

  localparam int N = 2;

  localparam logic [27:0] GRA   = 28'd1 << 0,  GRB   = 28'd1 << 1,  GRC   = 28'd1 << 2;
  localparam logic [27:0] RIN   = 28'd1 << 3,  ROUT  = 28'd1 << 4,  BAOUT = 28'd1 << 5;
  localparam logic [27:0] PCOUT = 28'd1 << 6,  INCPC = 28'd1 << 7,  PCEN  = 28'd1 << 8;
  localparam logic [27:0] IRIN  = 28'd1 << 9,  JAL15 = 28'd1 << 10, YIN   = 28'd1 << 11;
  localparam logic [27:0] HIOUT = 28'd1 << 12, HIIN  = 28'd1 << 13, LOOUT = 28'd1 << 14;
  localparam logic [27:0] LOIN  = 28'd1 << 15, COUT  = 28'd1 << 16, ZHI   = 28'd1 << 17;
  localparam logic [27:0] ZLO   = 28'd1 << 18, ZIN   = 28'd1 << 19, MDROUT = 28'd1 << 20;
  localparam logic [27:0] MDRIN = 28'd1 << 21, MARIN = 28'd1 << 22, MRD   = 28'd1 << 23;
  localparam logic [27:0] MWR   = 28'd1 << 24, CONIN = 28'd1 << 25, INP   = 28'd1 << 26;
  localparam logic [27:0] OUTP  = 28'd1 << 27;
  localparam logic [4:0]  NOP = 5'b11010, ADD = 5'b00011;

  logic clock = 1'b0, clear = 1'b1, con_ff = 1'b0;
  logic [31:0] ir = '0;
  logic run, Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IRin, jal_R15;
  logic Yin, HIout, HIin, LOout, LOin, Cout, Zhighout, Zlowout, Zin;
  logic MDRout, MDRin, MARin, memRead, memWrite, CONin, inPortOut, outPort_en;
  logic [4:0] opcode;
`ifdef CTRL_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  control_sequencer #(.MEM_WAIT_CYCLES(N)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .run(run), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout_en(PCout_en), .IncPC(IncPC), .PC_en(PC_en), .IRin(IRin), .jal_R15(jal_R15),
    .Yin(Yin), .HIout(HIout), .HIin(HIin), .LOout(LOout), .LOin(LOin), .Cout(Cout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Zin(Zin), .MDRout(MDRout), .MDRin(MDRin),
    .MARin(MARin), .memRead(memRead), .memWrite(memWrite), .CONin(CONin),
    .inPortOut(inPortOut), .outPort_en(outPort_en), .opcode(opcode)
  );

  always #5 clock = ~clock;

  wire [27:0] obs = {outPort_en, inPortOut, CONin, memWrite, memRead, MARin, MDRin, MDRout,
                     Zin, Zlowout, Zhighout, Cout, LOin, LOout, HIin, HIout, Yin, jal_R15,
                     IRin, PC_en, IncPC, PCout_en, BAout, Rout, Rin, Grc, Grb, Gra};

  int n_pass = 0, n_total = 0;

  logic [27:0] q_s[$];
  logic [4:0]  q_op[$];
  bit          q_run[$];
  bit          q_cff[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, o, e);
  endtask

  task automatic push(input logic [27:0] s, input logic [4:0] op, input bit r, input bit cf);
    q_s.push_back(s); q_op.push_back(op); q_run.push_back(r); q_cff.push_back(cf);
  endtask

  // Expected cycle list for one instruction: fetch, waits, then the execute table row.
  task automatic build(input logic [31:0] instr);
    logic [4:0] op = instr[31:27];
    push(PCOUT | MARIN | INCPC | ZIN, NOP, 1, 0);
    push(ZLO | PCEN | MRD | MDRIN, NOP, 1, 0);
    for (int w = 0; w < N; w++) push(MRD | MDRIN, NOP, 1, 0);
    push(MDROUT | IRIN, NOP, 1, 0);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(GRB | ROUT | YIN, NOP, 1, 0);
      push(GRC | ROUT | ZIN, op, 1, 0);
      push(ZLO | GRA | RIN, NOP, 1, 0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(GRB | ROUT | YIN, NOP, 1, 0);
      push(COUT | ZIN, op, 1, 0);
      push(ZLO | GRA | RIN, NOP, 1, 0);
    end else if (op <= 5'd2) begin
      push(GRB | BAOUT | YIN, NOP, 1, 0);
      push(COUT | ZIN, ADD, 1, 0);
      if (op == 5'd1) push(ZLO | GRA | RIN, NOP, 1, 0);
      else begin
        push(ZLO | MARIN, NOP, 1, 0);
        if (op == 5'd0) begin
          push(MRD | MDRIN, NOP, 1, 0);
          for (int w = 0; w < N; w++) push(MRD | MDRIN, NOP, 1, 0);
          push(MDROUT | GRA | RIN, NOP, 1, 0);
        end else begin
          push(GRA | ROUT | MDRIN, NOP, 1, 0);
          for (int w = 0; w <= N; w++) push(MWR, NOP, 1, 0);
        end
      end
    end else begin
      case (op)
        5'd15, 5'd16: begin
          push(GRA | ROUT | YIN, NOP, 1, 0);
          push(GRB | ROUT | ZIN, op, 1, 0);
          push(ZLO | LOIN, NOP, 1, 0);
          push(ZHI | HIIN, NOP, 1, 0);
        end
        5'd17, 5'd18: begin
          push(GRB | ROUT | ZIN, op, 1, 0);
          push(ZLO | GRA | RIN, NOP, 1, 0);
        end
        5'd19: begin
          push(GRA | ROUT | CONIN, NOP, 1, 0);
          push(PCOUT | YIN, NOP, 1, 0);
          push(COUT | ZIN, ADD, 1, 0);
          push(ZLO, NOP, 1, 1);
        end
        5'd20: push(GRA | ROUT | PCEN, NOP, 1, 0);
        5'd21: begin
          push(PCOUT | JAL15 | RIN, NOP, 1, 0);
          push(GRA | ROUT | PCEN, NOP, 1, 0);
        end
        5'd22: push(INP | GRA | RIN, NOP, 1, 0);
        5'd23: push(GRA | ROUT | OUTP, NOP, 1, 0);
        5'd24: push(HIOUT | GRA | RIN, NOP, 1, 0);
        5'd25: push(LOOUT | GRA | RIN, NOP, 1, 0);
        5'd27: for (int h = 0; h < 20; h++) push('0, NOP, 0, 0);
        default: ;
      endcase
    end
  endtask

  // Called at a negedge with the DUT in F0; returns at the negedge after the last cycle.
  task automatic exec(input int idx, input logic [31:0] instr, input int cff_force);
    logic [27:0] e_s;
    int c = 0;
    ir = instr;
    build(instr);
    while (q_s.size() > 0) begin
      e_s = q_s.pop_front();
      con_ff = (cff_force < 0) ? 1'($urandom_range(0, 1)) : (cff_force != 0);
      #1;
      if (q_cff.pop_front() && con_ff) e_s = e_s | PCEN;
      chk($sformatf("i%0d ir=%h c%0d strobes", idx, instr, c), 32'(obs), 32'(e_s));
      chk($sformatf("i%0d ir=%h c%0d opcode", idx, instr, c), 32'(opcode), 32'(q_op.pop_front()));
      chk($sformatf("i%0d ir=%h c%0d run", idx, instr, c), 32'(run), 32'(q_run.pop_front()));
      c++;
      @(posedge clock); @(negedge clock);
    end
    $display("instr %0d ir=%h op=%b cycles=%0d", idx, instr, instr[31:27], c);
  endtask

  task automatic check_reset(input string tag);
    #1;
    chk({tag, " strobes"}, 32'(obs), 32'(0));
    chk({tag, " opcode"}, 32'(opcode), 32'(NOP));
    chk({tag, " run"}, 32'(run), 32'(1));
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] rir;
    #2 clear = 1'b0;
    ir = 'x;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_reset($sformatf("reset c%0d", i));
    end
    clear = 1'b1;
    @(posedge clock); @(negedge clock);

    exec(0, 32'h18918000, -1);
    exec(1, 32'h98980008, 1);
    exec(2, 32'h98980008, 0);
    exec(3, 32'h11080063, -1);
    exec(4, 32'hAA000000, -1);
    exec(5, 32'h00880010, -1);
    exec(6, 32'hE0000000, -1);
    for (int i = 7; i < 47; i++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'b11011) rop = NOP;
      rir = {rop, 27'($urandom)};
      exec(i, rir, -1);
    end
    exec(47, 32'hD8000000, -1);

    clear = 1'b0;
    check_reset("halt clear");
    @(posedge clock); @(negedge clock);
    clear = 1'b1;
    @(posedge clock); @(negedge clock);
    exec(48, 32'h18918000, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
